id_ex_stage: RTL
================

# id_ex_stage

Pipeline register between decode and execute. Captures the control packet produced by the decode-stage control ROM, together with the decoded operands. Detects load-use hazards and inserts bubbles. Provides the stall/hold signal back to IF/ID. Counts inserted load-use bubbles for performance analysis.

## Interface
- `CNT_W`, default 32: width of the bubble counter; saturates at all-ones.

Ports:
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  decode slot holds a real instruction.
- `id_opcode`  in  `rv32i_opcode`  decoded opcode.
- `id_ctrl`  in  `rv32i_ctrl_packet_t`  control packet from the control ROM.
- `id_pc`  in  32  PC of the decode instruction.
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register indices.
- `id_rs1_data`, `id_rs2_data`  in  32 each  regfile read data.
- `id_imm`  in  32  selected immediate.
- `id_funct3`  in  3  funct3 field.
- `ex_ready`  in  1  EX/MEM can accept; 0 holds this stage.
- `flush`  in  1  branch/jump redirect resolved; kill the decode instruction.
- `ex_pkt`  out  `id_ex_packet_t`  registered bundle of all `id_*` fields above.
- `ex_valid`  out  1  registered valid.
- `id_stall`  out  1  combinational; hold PC and IF/ID.
- `bubble_cnt`  out  `CNT_W`  load-use bubbles inserted since reset.

## Operation
Usage flags:
- `uses_rs1` = opcode not in {lui, auipc, jal}.
- `uses_rs2` = opcode in {br, store, reg}.

Load-use hazard (combinational) = all of:
- `ex_valid` and `ex_pkt.ctrl.data_mem_read`.
- `ex_pkt.rd != 0`.
- `id_valid`.
- At least one of: (`uses_rs1` and `id_rs1 == ex_pkt.rd`), or (`uses_rs2` and `id_rs2 == ex_pkt.rd`).

`id_stall` = `!ex_ready | hazard`.

Register update at each rising edge, priority highest first:
1. `ex_ready` = 0: HOLD. All outputs keep their value; `flush` and `hazard` are ignored. The flush source keeps `flush` asserted until `ex_ready` = 1.
2. `flush` = 1: BUBBLE.
3. `hazard` = 1: BUBBLE, and `bubble_cnt` += 1 (saturating).
4. Otherwise: LOAD. Capture all `id_*` fields; `ex_valid` <= `id_valid`.

BUBBLE means:
- `ex_valid` = 0.
- Entire `ex_pkt` is zero, including `ctrl.load_regfile`, `data_mem_read`, `data_mem_write`, `data_mem_byte_enable`, and the `ex`/`mem`/`wb` fields.

An invalid `id` slot that is loaded is forced to the bubble value, not captured. This ensures downstream never sees stray write enables.

Flush and hazard in the same cycle: flush wins, so the counter does not increment.

## Timing
- Reset (`rst` low, asynchronous) forces `ex_valid` = 0, `ex_pkt` = all zero, and `bubble_cnt` = 0, immediately and independent of `clk`.
- Release of `rst` is synchronised externally. The first edge after release operates normally.
- Latency: one cycle. `id_*` values sampled at edge N appear on `ex_*` after edge N.
- Load-use penalty: exactly one bubble. On the next cycle the load is in MEM, `hazard` = 0, and the dependent instruction loads. Downstream forwarding from MEM/WB supplies the value.
- `id_stall` has no registered component. It changes in the same cycle as `ex_ready` or `ex_pkt`.
- Reset asserted mid-stall drops any held instruction. No state survives reset.

## Structure
- Add `id_ex_packet_t` (a struct holding `ctrl`, `opcode`, `pc`, `rs1`, `rs2`, `rd`, `rs1_data`, `rs2_data`, `imm`, `funct3`) to the `rv32i_packet` package. Define a matching `ID_EX_BUBBLE` constant there as well.
- The `uses_rs1`/`uses_rs2` derivation and the hazard compare form one natural sub-module, `load_use_detect`. It is purely combinational and instantiated once.
- The register, the priority logic, and the counter stay in `id_ex_stage`.

## Test plan
- **Reset:** assert `rst` = 0 mid-cycle with `ex_valid` = 1 → `ex_valid`, `ex_pkt`, and `bubble_cnt` read 0 before the next edge.
- **Load-use:** `lw x5,0(x1)` followed by `add x6,x5,x2` → one edge with `id_stall` = 1, then `ex_valid` = 0, then `add` loads; `bubble_cnt` = 1. Repeat with rd = x0 → no stall.
- **Non-use:** `lw x5` followed by `lui x5,0x1` or `jal x5` → no stall (`uses_rs1` = 0). `lw x5` followed by `sw x5,0(x3)` → stall via rs2.
- **Downstream stall:** `ex_ready` = 0 for 3 cycles with `flush` = 1 and a hazard present → `ex_pkt` unchanged, `bubble_cnt` unchanged. When `ex_ready` returns to 1 with `flush` = 1 → bubble, counter unchanged.
- **Flush:** `flush` = 1 with a valid `add` in decode → `ex_valid` = 0 and `ex_pkt.ctrl.load_regfile` = 0 next cycle.
- **Saturation:** with `CNT_W` = 4, run 17 load-use pairs → `bubble_cnt` stops at 15.

Source files
------------

// File: rtl/rv32i_packet.sv
// Shared RV32I pipeline types: opcodes, control-ROM packet, ID/EX packet and its bubble value.
package rv32i_packet;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    // Grouped by consuming stage: ex, mem, wb
    typedef struct packed {
        logic [3:0] aluop;
        logic       alumux1_sel;
        logic [2:0] alumux2_sel;
        logic [2:0] cmpop;
        logic       cmpmux_sel;
        logic       data_mem_read;
        logic       data_mem_write;
        logic [3:0] data_mem_byte_enable;
        logic       load_regfile;
        logic [3:0] regfilemux_sel;
    } rv32i_ctrl_packet_t;

    typedef struct packed {
        rv32i_ctrl_packet_t ctrl;
        rv32i_opcode        opcode;
        logic [31:0]        pc;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic [31:0]        rs1_data;
        logic [31:0]        rs2_data;
        logic [31:0]        imm;
        logic [2:0]         funct3;
    } id_ex_packet_t;

    localparam id_ex_packet_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: decode fields and downstream ready in, registered packet and stall out.
interface id_ex_stage_if;
    import rv32i_packet::*;

    logic               id_valid;
    rv32i_opcode        id_opcode;
    rv32i_ctrl_packet_t id_ctrl;
    logic [31:0]        id_pc;
    logic [4:0]         id_rs1;
    logic [4:0]         id_rs2;
    logic [4:0]         id_rd;
    logic [31:0]        id_rs1_data;
    logic [31:0]        id_rs2_data;
    logic [31:0]        id_imm;
    logic [2:0]         id_funct3;
    logic               ex_ready;
    logic               flush;
    id_ex_packet_t      ex_pkt;
    logic               ex_valid;
    logic               id_stall;

    modport master (
        output id_valid, id_opcode, id_ctrl, id_pc, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_funct3, ex_ready, flush,
        input  ex_pkt, ex_valid, id_stall
    );

    modport slave (
        input  id_valid, id_opcode, id_ctrl, id_pc, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_funct3, ex_ready, flush,
        output ex_pkt, ex_valid, id_stall
    );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard between the decode instruction and a load sitting in EX.
// Purely combinational; no latency, no backpressure of its own.
module load_use_detect
    import rv32i_packet::*;
(
    input  logic        id_valid,
    input  rv32i_opcode id_opcode,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    output logic        hazard
);

    logic uses_rs1;
    logic uses_rs2;

    // Opcodes without a real rs1/rs2 field carry garbage there; mask it out
    assign uses_rs1 = !(id_opcode inside {op_lui, op_auipc, op_jal});
    assign uses_rs2 = id_opcode inside {op_br, op_store, op_reg};

    assign hazard = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
                    ((uses_rs1 && (id_rs1 == ex_rd)) || (uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and saturating bubble counter.
// One-cycle latency; ex_ready low holds everything, id_stall is combinational back to IF/ID.
module id_ex_stage
    import rv32i_packet::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    id_ex_stage_if.slave     bus,
    output logic [CNT_W-1:0] bubble_cnt
);

    id_ex_packet_t pkt_q;
    id_ex_packet_t load_pkt;
    logic          valid_q;
    logic          hazard;

    load_use_detect u_load_use_detect (
        .id_valid    (bus.id_valid),
        .id_opcode   (bus.id_opcode),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .ex_valid    (valid_q),
        .ex_mem_read (pkt_q.ctrl.data_mem_read),
        .ex_rd       (pkt_q.rd),
        .hazard      (hazard)
    );

    // Invalid decode slots become bubbles so no stray write enables leak downstream
    always_comb begin
        load_pkt = ID_EX_BUBBLE;
        if (bus.id_valid) begin
            load_pkt.ctrl     = bus.id_ctrl;
            load_pkt.opcode   = bus.id_opcode;
            load_pkt.pc       = bus.id_pc;
            load_pkt.rs1      = bus.id_rs1;
            load_pkt.rs2      = bus.id_rs2;
            load_pkt.rd       = bus.id_rd;
            load_pkt.rs1_data = bus.id_rs1_data;
            load_pkt.rs2_data = bus.id_rs2_data;
            load_pkt.imm      = bus.id_imm;
            load_pkt.funct3   = bus.id_funct3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_q      <= ID_EX_BUBBLE;
            valid_q    <= 1'b0;
            bubble_cnt <= '0;
        end else if (bus.ex_ready) begin
            if (bus.flush) begin
                pkt_q   <= ID_EX_BUBBLE;
                valid_q <= 1'b0;
            end else if (hazard) begin
                pkt_q   <= ID_EX_BUBBLE;
                valid_q <= 1'b0;
                if (bubble_cnt != {CNT_W{1'b1}}) begin
                    bubble_cnt <= bubble_cnt + CNT_W'(1);
                end
            end else begin
                pkt_q   <= load_pkt;
                valid_q <= bus.id_valid;
            end
        end
    end

    assign bus.ex_pkt   = pkt_q;
    assign bus.ex_valid = valid_q;
    assign bus.id_stall = !bus.ex_ready || hazard;

endmodule
